// File: rtl/ddma_send_scheduler_pkg.sv
// Shared types and constants for the DDMA send scheduler.
//   word_t        : one MMIO data/address word
//   send_desc_t   : a queued send descriptor {dest, addr, size}
//   sched_state_t : issue FSM states
//   REG_*         : MMIO word register indices
//   ST_* / CTRL_* / ERR_* : bit positions inside STATUS, CTRL and err
package ddma_send_scheduler_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t dest;
        word_t addr;
        word_t size;
    } send_desc_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_REL = 2'd3
    } sched_state_t;

    localparam logic [2:0] REG_DEST   = 3'd0;
    localparam logic [2:0] REG_ADDR   = 3'd1;
    localparam logic [2:0] REG_SIZE   = 3'd2;
    localparam logic [2:0] REG_PUSH   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_DONE   = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_COUNT_W   = 8;
    localparam int ST_EMPTY     = 8;
    localparam int ST_FULL      = 9;
    localparam int ST_BUSY      = 10;
    localparam int ST_ERR_LSB   = 11;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLEAR   = 1;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_TIMEOUT  = 1;

endpackage

// File: rtl/ddma_send_scheduler_desc_fifo.sv
// Circular descriptor FIFO for the DDMA send scheduler.
// Ports:
//   clock, reset  : clock, synchronous active-low reset (flushes pointers/count)
//   push_i/data_i : enqueue request; dropped when full unless popping the same cycle
//   pop_i         : dequeue request; ignored when empty
//   head_o        : entry at the read pointer
//   full_o/empty_o/count_o : occupancy
module desc_fifo
    import ddma_send_scheduler_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = send_desc_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    T               mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW:0]    count_q;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A pop frees a slot on the same edge, so a push while full is still accepted then.
    assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (PW+1)'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ddma_send_scheduler.sv
// DDMA send scheduler: queues CPU-posted send descriptors and issues them to
// the DDMA send engine one at a time over a 4-phase cmd/ack handshake.
// Ports:
//   clock, reset             : clock, synchronous active-low reset
//   reg_wr_in/reg_rd_in      : MMIO write/read strobes
//   reg_idx_in/reg_data_in   : word register index and write data
//   reg_data_out             : registered read data (one cycle after reg_rd_in)
//   send_dest/addr/size_out  : descriptor presented to the DDMA
//   send_cmd_out/send_ack_in : 4-phase handshake with the DDMA
//   irq_out                  : level completion interrupt
// MEMORY_WIDTH must equal WORD_W of the package (descriptor fields are word_t).
//
// Handshake: the descriptor is registered one cycle before cmd rises and is
// held until the next pop. cmd stays high until ack is seen high, then falls;
// the transfer completes when ack is seen low again. A new cmd is never raised
// while ack is still high. Either wait phase gives up after ACK_TIMEOUT cycles.
module ddma_send_scheduler
    import ddma_send_scheduler_pkg::*;
#(
    parameter int MEMORY_WIDTH = WORD_W,
    parameter int QUEUE_DEPTH  = 4,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    reg_wr_in,
    input  logic                    reg_rd_in,
    input  logic [2:0]              reg_idx_in,
    input  logic [MEMORY_WIDTH-1:0] reg_data_in,
    output logic [MEMORY_WIDTH-1:0] reg_data_out,
    output logic [MEMORY_WIDTH-1:0] send_dest_out,
    output logic [MEMORY_WIDTH-1:0] send_addr_out,
    output logic [MEMORY_WIDTH-1:0] send_size_out,
    output logic                    send_cmd_out,
    input  logic                    send_ack_in,
    output logic                    irq_out
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(ACK_TIMEOUT);

    sched_state_t   state_q;
    logic           cmd_q;
    word_t          send_dest_q, send_addr_q, send_size_q;
    logic [TW-1:0]  timer_q;

    word_t          dest_q, addr_q, size_q;
    word_t          done_count_q, done_count_d;
    logic [1:0]     err_q, err_d;
    logic           irq_en_q;
    logic           pending_q, pending_d;
    word_t          reg_data_q, rd_data_d;

    send_desc_t       stage_desc, head_desc;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic wr_push, wr_done, ctrl_clear;
    logic pop, complete, ack_timeout, overflow;

    assign wr_push    = reg_wr_in && (reg_idx_in == REG_PUSH);
    assign wr_done    = reg_wr_in && (reg_idx_in == REG_DONE);
    assign ctrl_clear = reg_wr_in && (reg_idx_in == REG_CTRL) && reg_data_in[CTRL_CLEAR];

    // An ack still high from a previous transfer blocks the next issue.
    assign pop         = (state_q == IDLE) && !fifo_empty && !send_ack_in;
    assign complete    = (state_q == WAIT_REL) && !send_ack_in;
    assign ack_timeout = (timer_q == TIMER_MAX) &&
                         (((state_q == WAIT_ACK) && !send_ack_in) ||
                          ((state_q == WAIT_REL) &&  send_ack_in));
    assign overflow    = wr_push && fifo_full && !pop;

    assign stage_desc = '{dest: dest_q, addr: addr_q, size: size_q};

    desc_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (send_desc_t)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (wr_push),
        .data_i  (stage_desc),
        .pop_i   (pop),
        .head_o  (head_desc),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Issue FSM with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_q       <= 1'b0;
            send_dest_q <= '0;
            send_addr_q <= '0;
            send_size_q <= '0;
            timer_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        send_dest_q <= head_desc.dest;
                        send_addr_q <= head_desc.addr;
                        send_size_q <= head_desc.size;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_q   <= 1'b1;
                    timer_q <= TW'(1);
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (send_ack_in) begin
                        cmd_q   <= 1'b0;
                        timer_q <= TW'(1);
                        state_q <= WAIT_REL;
                    end else if (ack_timeout) begin
                        // Descriptor is abandoned; the DDMA sees cmd withdrawn.
                        cmd_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_REL: begin
                    if (!send_ack_in || ack_timeout) state_q <= IDLE;
                    else                             timer_q <= timer_q + TW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky error and interrupt state: new events win over a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (ctrl_clear) err_d = 2'b00;
        if (overflow)    err_d[ERR_OVERFLOW] = 1'b1;
        if (ack_timeout) err_d[ERR_TIMEOUT]  = 1'b1;

        pending_d = pending_q && !ctrl_clear;
        if (complete && irq_en_q) pending_d = 1'b1;

        done_count_d = done_count_q;
        if (wr_done)  done_count_d = '0;
        if (complete) done_count_d = done_count_d + 32'd1;
    end

    always_comb begin
        rd_data_d = '0;
        case (reg_idx_in)
            REG_DEST:   rd_data_d = dest_q;
            REG_ADDR:   rd_data_d = addr_q;
            REG_SIZE:   rd_data_d = size_q;
            REG_STATUS: begin
                rd_data_d[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
                rd_data_d[ST_EMPTY]                   = fifo_empty;
                rd_data_d[ST_FULL]                    = fifo_full;
                rd_data_d[ST_BUSY]                    = (state_q != IDLE);
                rd_data_d[ST_ERR_LSB +: 2]            = err_q;
            end
            REG_DONE:   rd_data_d = done_count_q;
            REG_CTRL:   rd_data_d[CTRL_IRQ_EN] = irq_en_q;
            default:    rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dest_q       <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            irq_en_q     <= 1'b0;
            err_q        <= 2'b00;
            pending_q    <= 1'b0;
            done_count_q <= '0;
            reg_data_q   <= '0;
        end else begin
            if (reg_wr_in) begin
                case (reg_idx_in)
                    REG_DEST: dest_q   <= reg_data_in;
                    REG_ADDR: addr_q   <= reg_data_in;
                    REG_SIZE: size_q   <= reg_data_in;
                    REG_CTRL: irq_en_q <= reg_data_in[CTRL_IRQ_EN];
                    default: ;
                endcase
            end
            err_q        <= err_d;
            pending_q    <= pending_d;
            done_count_q <= done_count_d;
            if (reg_rd_in) reg_data_q <= rd_data_d;
        end
    end

    assign reg_data_out  = reg_data_q;
    assign send_dest_out = send_dest_q;
    assign send_addr_out = send_addr_q;
    assign send_size_out = send_size_q;
    assign send_cmd_out  = cmd_q;
    assign irq_out       = pending_q && irq_en_q;

endmodule
